// File: rtl/present_pkg.sv
// present_pkg: shared constants, types and helpers for the PRESENT-80 core.
//   fsm_t       : controller state encoding (IDLE/ROUND/DONE)
//   ROUND_LAST  : index of the final round
//   SBOX_TBL    : 4-bit S-box, entry n sits in bits [4n+3:4n]
//   sbox()      : single-nibble substitution
//   player()    : 64-bit bit permutation
package present_pkg;

  localparam int STATE_W = 64;
  localparam int KEY_W   = 80;
  localparam int NIBBLES = STATE_W / 4;

  localparam logic [4:0] ROUND_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // S(0..F) = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 ; written MSB nibble first
  localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  // bit j -> (16*j) mod 63, bit 63 fixed
  function automatic logic [STATE_W-1:0] player(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int j = 0; j < STATE_W - 1; j++)
      y[(16 * j) % 63] = x[j];
    y[STATE_W-1] = x[STATE_W-1];
    return y;
  endfunction

endpackage

// File: rtl/key_schedule.sv
// key_schedule: combinational PRESENT-80 key update.
//   key      : current 80-bit key register
//   rnd      : 5-bit round counter value mixed into bits [19:15]
//   key_next : key after rotate-left-61, S-box on top nibble, counter xor
module key_schedule
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       rnd,
  output logic [KEY_W-1:0] key_next
);

  logic [KEY_W-1:0] rot;

  assign rot = {key[18:0], key[79:19]};

  always_comb begin
    key_next         = rot;
    key_next[79:76]  = sbox(rot[79:76]);
    key_next[19:15]  = rot[19:15] ^ rnd;
  end

endmodule

// File: rtl/present_round.sv
// present_round: one combinational PRESENT round, y = pLayer(sBox(x ^ k)).
//   x : 64-bit cipher state
//   k : 64-bit round key (top 64 bits of the key register)
//   y : 64-bit round output
module present_round
  import present_pkg::*;
(
  input  logic [STATE_W-1:0] x,
  input  logic [STATE_W-1:0] k,
  output logic [STATE_W-1:0] y
);

  logic [STATE_W-1:0] t;
  logic [STATE_W-1:0] s;

  assign t = x ^ k;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_sbox
    assign s[4*g +: 4] = sbox(t[4*g +: 4]);
  end

  assign y = player(s);

endmodule

// File: rtl/present_enc_iter.sv
// present_enc_iter: iterative PRESENT-80 encryption, one round per clock.
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   req : 4-phase request; a 0->1 level seen in IDLE starts an operation
//   m   : 64-bit plaintext, sampled on the load edge only
//   k   : 80-bit key, sampled on the load edge only
//   ack : high from completion until req is seen low in DONE
//   r   : 64-bit ciphertext, held until the next completion or reset
module present_enc_iter
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [STATE_W-1:0] m,
  input  logic [KEY_W-1:0]   k,
  output logic               ack,
  output logic [STATE_W-1:0] r
);

  fsm_t               fsm, fsm_nxt;
  logic [4:0]         i, i_nxt;
  logic [STATE_W-1:0] st, st_nxt;
  logic [KEY_W-1:0]   key, key_nxt;
  logic [STATE_W-1:0] r_nxt;
  logic               ack_nxt;

  logic [STATE_W-1:0] rnd_out;
  logic [KEY_W-1:0]   ks_out;

  // single round datapath, shared by the iteration and the final whitening
  present_round u_round (
    .x (st),
    .k (key[79:16]),
    .y (rnd_out)
  );

  key_schedule u_ks (
    .key      (key),
    .rnd      (i),
    .key_next (ks_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm <= IDLE;
      i   <= '0;
      st  <= '0;
      key <= '0;
      r   <= '0;
      ack <= 1'b0;
    end else begin
      fsm <= fsm_nxt;
      i   <= i_nxt;
      st  <= st_nxt;
      key <= key_nxt;
      r   <= r_nxt;
      ack <= ack_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    i_nxt   = i;
    st_nxt  = st;
    key_nxt = key;
    r_nxt   = r;
    ack_nxt = ack;
    case (fsm)
      IDLE: begin
        if (req) begin
          st_nxt  = m;
          key_nxt = k;
          i_nxt   = 5'd1;
          fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        if (i == ROUND_LAST) begin
          // round 31 plus the post-whitening with K32, straight into r
          r_nxt   = rnd_out ^ ks_out[79:16];
          ack_nxt = 1'b1;
          fsm_nxt = DONE;
        end else begin
          st_nxt  = rnd_out;
          key_nxt = ks_out;
          i_nxt   = i + 5'd1;
        end
      end
      DONE: begin
        if (!req) begin
          ack_nxt = 1'b0;
          fsm_nxt = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_present_enc_iter.sv
// tb_present_enc_iter: table-driven known-answer checks with a scoreboard
// queue, plus hand-written reset-abort, input-scramble and req-hold cases.
module tb_present_enc_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [63:0] m;
  logic [79:0] k;
  logic        ack;
  logic [63:0] r;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];

  typedef struct {
    logic [63:0] m;
    logic [79:0] k;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  present_enc_iter dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .m   (m),
    .k   (k),
    .ack (ack),
    .r   (r)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation, waits for ack with a bounded budget, checks latency
  // and result, optionally holds req high after ack, then returns req to 0.
  task automatic run_op(input string name, input logic [63:0] mv, input logic [79:0] kv,
                        input logic [63:0] exp, input int hold, input bit scramble);
    int          cyc;
    bit          got;
    logic [63:0] e;
    logic [95:0] rk;
    req = 1'b1;
    m   = mv;
    k   = kv;
    sb.push_back(exp);
    step();  // load edge 0
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      if (scramble) begin
        m  = {$urandom, $urandom};
        rk = {$urandom, $urandom, $urandom};
        k  = rk[79:0];
        if (cyc == 4) req = 1'b0;  // edge 5 sees req low
      end
      step();
      cyc++;
      if (ack) got = 1'b1;
    end
    chk({name, " latency"}, 64'(cyc), 64'd31);
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 64'd1, 64'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk({name, " r"}, r, e);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({name, " hold ack"}, 64'(ack), 64'd1);
      chk({name, " hold r"}, r, e);
    end
    req = 1'b0;
    step();
    chk({name, " ack low"}, 64'(ack), 64'd0);
    chk({name, " r kept"}, r, e);
  endtask

  initial begin
    vecs[0] = '{64'h0000000000000000, 80'h0,                    64'h5579c1387b228445};
    vecs[1] = '{64'h0000000000000000, 80'hFFFFFFFFFFFFFFFFFFFF, 64'he72c46c0f5945049};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 80'h0,                    64'ha112ffc72f68417b};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333dcd3213210d2};

    rst = 1'b0;
    req = 1'b0;
    m   = '0;
    k   = '0;
    step();
    step();
    chk("reset ack", 64'(ack), 64'd0);
    chk("reset r", r, 64'd0);
    rst = 1'b1;
    step();

    // back-to-back known answers; run_op confirms ack returns to 0 between
    for (int v = 0; v < 4; v++)
      run_op($sformatf("kat%0d", v), vecs[v].m, vecs[v].k, vecs[v].exp, 0, 1'b0);

    // reset on edge 10 of an operation aborts it and clears r/ack
    req = 1'b1;
    m   = 64'h0123456789ABCDEF;
    k   = 80'h1;
    step();  // load edge
    repeat (9) step();
    rst = 1'b0;
    step();  // edge 10
    chk("midreset ack", 64'(ack), 64'd0);
    chk("midreset r", r, 64'd0);
    rst = 1'b1;
    req = 1'b0;
    step();
    run_op("after reset", 64'h0, 80'h0, 64'h5579c1387b228445, 0, 1'b0);

    // inputs change every cycle and req drops at edge 5
    run_op("scramble", 64'h0, 80'h0, 64'h5579c1387b228445, 0, 1'b1);
    // FSM must be back in IDLE: a fresh request works normally
    run_op("post scramble", vecs[2].m, vecs[2].k, vecs[2].exp, 0, 1'b0);

    // req held 5 cycles past ack: nothing restarts, outputs stable
    run_op("hold", vecs[1].m, vecs[1].k, vecs[1].exp, 5, 1'b0);

    // no spurious activity while idle
    repeat (3) step();
    chk("idle ack", 64'(ack), 64'd0);
    chk("idle r", r, vecs[1].exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
